// File: rtl/muldiv_pkg.sv
// Shared types and default widths for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_ADDRESS_WIDTH = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational conditional two's-complement negate: absolute value of operands
// on the way in, sign restoration of the product/quotient/remainder on the way out.
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a fixed-latency shift-add / restoring divide core.
// Divide ops are built only with MULDIV_DIV_EN; otherwise op[2]=1 completes at once with result 0, we=0.
//
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// CALC  | DATA_WIDTH iteration steps, then one cycle to register the result
// DONE  | one-cycle completion pulse, result and rd_out valid
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic [ADDRESS_WIDTH-1:0] rd_in,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    result,
  output logic [ADDRESS_WIDTH-1:0] rd_out,
  output logic                     we
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  state_e                   state, state_nxt;
  op_e                      op_in, op_q;
  logic [CNT_W-1:0]         cnt;
  logic [DATA_WIDTH-1:0]    hi, lo, opnd, hi_nxt, lo_nxt;
  logic                     neg_q, neg_in, sign_a, sign_b;
  logic [ADDRESS_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]    abs_a, abs_b, res_val;
  logic [2*DATA_WIDTH-1:0]  prod_fix;
  logic [DATA_WIDTH:0]      mul_sum;
  logic                     accept, calc_last;

  assign op_in     = op_e'(op);
  assign accept    = (state == ST_IDLE) && start;
  assign calc_last = (state == ST_CALC) && (cnt == CNT_W'(DATA_WIDTH));
  assign sign_a    = rs1_data[DATA_WIDTH-1] &
                     (op_in == OP_MULH || op_in == OP_MULHSU || op_in == OP_DIV || op_in == OP_REM);
  assign sign_b    = rs2_data[DATA_WIDTH-1] &
                     (op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM);

  muldiv_signfix #(.WIDTH(DATA_WIDTH))   u_abs_a (.value(rs1_data), .neg(sign_a), .result(abs_a));
  muldiv_signfix #(.WIDTH(DATA_WIDTH))   u_abs_b (.value(rs2_data), .neg(sign_b), .result(abs_b));
  muldiv_signfix #(.WIDTH(2*DATA_WIDTH)) u_prod  (.value({hi, lo}), .neg(neg_q),  .result(prod_fix));

  // {hi,lo} is the product shift register; lo starts as the multiplier
  assign mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? opnd : {DATA_WIDTH{1'b0}})};

`ifdef MULDIV_DIV_EN
  logic [DATA_WIDTH:0]   shifted;
  logic                  ge;
  logic [DATA_WIDTH-1:0] sub, div_fix;

  // hi is the partial remainder, lo shifts the dividend out and the quotient in
  assign shifted = {hi, lo[DATA_WIDTH-1]};
  assign ge      = shifted >= {1'b0, opnd};
  assign sub     = shifted[DATA_WIDTH-1:0] - opnd;

  muldiv_signfix #(.WIDTH(DATA_WIDTH)) u_div (.value(op_q[1] ? hi : lo), .neg(neg_q), .result(div_fix));
`endif

  always_comb begin
    hi_nxt = mul_sum[DATA_WIDTH:1];
    lo_nxt = {mul_sum[0], lo[DATA_WIDTH-1:1]};
    res_val = (op_q == OP_MUL) ? prod_fix[DATA_WIDTH-1:0] : prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
    neg_in = sign_a ^ sign_b;
`ifdef MULDIV_DIV_EN
    if (op_q[2]) begin
      hi_nxt  = ge ? sub : shifted[DATA_WIDTH-1:0];
      lo_nxt  = {lo[DATA_WIDTH-2:0], ge};
      res_val = div_fix;
    end
    // zero divisor keeps the all-ones quotient unsigned; remainder follows the dividend
    if (op[2]) neg_in = op[1] ? sign_a : ((sign_a ^ sign_b) && (rs2_data != '0));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          state_nxt = ST_CALC;
`else
          state_nxt = op[2] ? ST_DONE : ST_CALC;
`endif
        end
      end
      ST_CALC: if (cnt == CNT_W'(DATA_WIDTH)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
`ifdef MULDIV_DIV_EN
    we   = done && (rd_out != '0);
`else
    we   = done && (rd_out != '0) && !op_q[2];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_MUL;
      rd_q   <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else if (accept) begin
      op_q  <= op_in;
      rd_q  <= rd_in;
      cnt   <= '0;
      hi    <= '0;
      neg_q <= neg_in;
`ifdef MULDIV_DIV_EN
      lo    <= op[2] ? abs_a : abs_b;
      opnd  <= op[2] ? abs_b : abs_a;
`else
      lo    <= abs_b;
      opnd  <= abs_a;
      if (op[2]) begin
        result <= '0;
        rd_out <= rd_in;
      end
`endif
    end else if (state == ST_CALC) begin
      if (calc_last) begin
        result <= res_val;
        rd_out <= rd_q;
      end else begin
        hi  <= hi_nxt;
        lo  <= lo_nxt;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, start-while-busy and reset-abort cases.
module tb_muldiv_unit;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [DW-1:0] rs1_data = '0, rs2_data = '0;
  logic [AW-1:0] rd_in = '0;
  logic          busy, done, we;
  logic [DW-1:0] result;
  logic [AW-1:0] rd_out;

  typedef struct {
    logic [DW-1:0] res;
    logic [AW-1:0] rd;
    logic          wen;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0, fails = 0, cyc = 0;
  logic prev_done = 1'b0;

  muldiv_unit #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .we(we)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse pops one expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 result=%h rd_out=%0d, required no done", result, rd_out);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("rd_out", DW'(rd_out), DW'(mon_e.rd));
        check("we", DW'(we), DW'(mon_e.wen));
        check("latency", DW'(cyc - mon_e.acc), DW'(mon_e.lat));
        check("done_pulse_prev", DW'(prev_done), '0);
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $display("FAIL idle_timeout: got busy=1 after %0d cycles, required busy=0", n);
        break;
      end
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [AW-1:0] rd, input logic [DW-1:0] r, input logic w,
                       input int lat, input bit push);
    exp_t e;
    wait_idle();
    op = o; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    e.res = r; e.rd = rd; e.wen = w; e.lat = lat; e.acc = cyc + 1;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_mul(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [AW-1:0] rd, input logic [DW-1:0] r);
    issue(o, a, b, rd, r, rd != '0, 33, 1'b1);
  endtask

  // Divide ops complete immediately with result 0 / we=0 when the divider is not built
  task automatic issue_div(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [AW-1:0] rd, input logic [DW-1:0] r);
    if (DIV_EN) issue(o, a, b, rd, r, rd != '0, 33, 1'b1);
    else        issue(o, a, b, rd, '0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_busy", DW'(busy), '0);
    check("rst_done", DW'(done), '0);
    check("rst_we", DW'(we), '0);
    check("rst_result", result, '0);
    check("rst_rd_out", DW'(rd_out), '0);
    rst_n = 1'b1;
    @(negedge clk);

    issue_mul(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    issue_mul(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000);
    issue_mul(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE);
    issue_mul(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF);
    issue_mul(3'b000, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 5'd10, 32'd6);
    issue_mul(3'b001, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 5'd11, 32'd0);
    issue_mul(3'b000, 32'd3, 32'd4, 5'd0, 32'd12);

    issue_div(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFD);
    issue_div(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFF);
    issue_div(3'b101, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF);
    issue_div(3'b111, 32'd5, 32'd0, 5'd15, 32'd5);
    issue_div(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000);
    issue_div(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0);
    issue_div(3'b100, 32'd9, 32'd3, 5'd18, 32'd3);
    issue_div(3'b100, 32'hFFFF_FFFB, 32'd0, 5'd19, 32'hFFFF_FFFF);
    issue_div(3'b110, 32'hFFFF_FFFB, 32'd0, 5'd20, 32'hFFFF_FFFB);

    // start pulsed while busy must be ignored
    issue_mul(3'b000, 32'h0001_2345, 32'h10, 5'd9, 32'h0012_3450);
    repeat (9) @(negedge clk);
    op = 3'b000; rs1_data = 32'd1; rs2_data = 32'd1; rd_in = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // reset mid-calculation aborts without a done pulse
    issue(3'b000, 32'd2, 32'd3, 5'd4, 32'd6, 1'b1, 33, 1'b0);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", DW'(busy), '0);
    check("abort_done", DW'(done), '0);
    check("abort_result", result, '0);
    check("abort_rd_out", DW'(rd_out), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    issue_mul(3'b011, 32'h0001_0000, 32'h0001_0000, 5'd21, 32'd1);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    wait_idle();
    @(negedge clk);
    check("scoreboard_drained", DW'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, setting the operand and result width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 5, setting the destination register index width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-006 The block SHALL have port op, input, 3 bits: RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 The block SHALL have port rs1_data, input, DATA_WIDTH: operand A (multiplicand or dividend), driven from register-file RD1.
REQ-008 The block SHALL have port rs2_data, input, DATA_WIDTH: operand B (multiplier or divisor), driven from register-file RD2.
REQ-009 The block SHALL have port rd_in, input, ADDRESS_WIDTH: destination register index.
REQ-010 The block SHALL have port busy, output, 1 bit: operation in flight, new start ignored.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port result, output, DATA_WIDTH: result value, feeding register-file WD3.
REQ-013 The block SHALL have port rd_out, output, ADDRESS_WIDTH: latched destination, feeding register-file AD3.
REQ-014 The block SHALL have port we, output, 1 bit: write enable, feeding register-file WE3.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and DONE.
REQ-016 In IDLE, start=1 SHALL latch op, rs1_data, rs2_data and rd_in, then move to CALC with the iteration counter at 0.
REQ-017 CALC SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle for exactly DATA_WIDTH cycles, then move to DONE.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-019 done SHALL be 1 only in DONE, so it is high exactly during the cycle after the 33rd rising edge following the accepting edge (DATA_WIDTH=32).
REQ-020 busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-021 start SHALL be ignored while busy=1, and a start asserted in the DONE cycle SHALL be ignored.
REQ-022 Latency SHALL be fixed and SHALL NOT depend on operand values, including zero divisor and overflow cases.
REQ-023 result and rd_out SHALL hold their values from DONE until the next DONE.
REQ-024 we SHALL equal done AND (rd_out != 0).
REQ-025 Signed operations SHALL compute on absolute values and negate the result when the signs differ; the remainder SHALL take the sign of the dividend.
REQ-026 MUL SHALL return product bits [31:0]; MULH, MULHSU and MULHU SHALL return bits [63:32] of the 64-bit product, with MULHSU treating A as signed and B as unsigned.
REQ-027 For a zero divisor, the quotient SHALL be all-ones and the remainder SHALL equal the dividend.
REQ-028 For DIV/REM with 0x80000000 / 0xFFFFFFFF, the quotient SHALL be 0x80000000 and the remainder SHALL be 0.

Reset
REQ-029 When rst_n=0 (asynchronous), the FSM SHALL go to IDLE and the counter, busy, done, we, result and rd_out SHALL all be 0.
REQ-030 A reset during CALC SHALL abort the operation without producing a done pulse.
REQ-031 After rst_n is released, the first start SHALL be accepted normally.

Configuration
REQ-032 With macro MULDIV_DIV_EN defined, all eight ops SHALL be implemented.
REQ-033 Without MULDIV_DIV_EN, an op with op[2]=1 SHALL be accepted, skip CALC (IDLE->DONE, done one cycle after acceptance), and return result 0 with we=0; no divider logic SHALL be synthesised.

Structure
REQ-034 Package muldiv_pkg SHALL hold the funct3 op enum typedef, the FSM state enum typedef and the DATA_WIDTH/ADDRESS_WIDTH defaults.
REQ-035 Sub-module muldiv_signfix (combinational absolute value, conditional negate) SHALL be instantiated for operand and result sign handling; there SHALL be no other sub-modules.

Verification
REQ-036 A bench SHALL cover: MUL, A=7, B=0xFFFFFFFD, rd_in=5 -> result 0xFFFFFFEB, rd_out=5, done and we high for one cycle, 33 edges after acceptance.
REQ-037 A bench SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-038 A bench SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
REQ-039 A bench SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-040 A bench SHALL cover: start pulsed at edge 10 of an operation in flight -> ignored, original result returned; rst_n=0 at edge 12 -> busy=0, no done ever.
REQ-041 A bench SHALL cover: MUL with rd_in=0 -> done=1, we=0; without MULDIV_DIV_EN, DIV 9 / 3 -> done one cycle after acceptance, result 0, we=0.
